// File: rtl/regfile_wb_ctrl_if.sv
// Writeback/scoreboard bus of regfile_wb_ctrl: two writeback sources, decode
// issue/query side and the register file write port.
interface regfile_wb_ctrl_if;
  logic        s0_valid, s0_ready;
  logic [4:0]  s0_rd;
  logic [31:0] s0_wd;
  logic        s1_valid, s1_ready;
  logic [4:0]  s1_rd;
  logic [31:0] s1_wd;
  logic        mark_valid, mark_ready;
  logic [4:0]  mark_rd;
  logic        flush;
  logic [4:0]  rs1_q, rs2_q;
  logic        rs1_busy, rs2_busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        err_underflow;

  modport slave (
    input  s0_valid, s0_rd, s0_wd, s1_valid, s1_rd, s1_wd,
           mark_valid, mark_rd, flush, rs1_q, rs2_q,
    output s0_ready, s1_ready, mark_ready, rs1_busy, rs2_busy,
           rf_we, rf_rd, rf_wd, err_underflow
  );

  modport master (
    output s0_valid, s0_rd, s0_wd, s1_valid, s1_rd, s1_wd,
           mark_valid, mark_rd, flush, rs1_q, rs2_q,
    input  s0_ready, s1_ready, mark_ready, rs1_busy, rs2_busy,
           rf_we, rf_rd, rf_wd, err_underflow
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Register file write-port owner: arbitrates ALU/LSU writebacks onto one
// registered write port and keeps a per-register pending-write scoreboard.

// One pending-write counter; inc and dec together cancel, flush wins.
module regfile_wb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_cnt
);
  // counter update
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                o_cnt <= '0;
    else if (i_flush)          o_cnt <= '0;
    else if (i_inc && !i_dec)  o_cnt <= o_cnt + CNT_W'(1);
    else if (i_dec && !i_inc)  o_cnt <= o_cnt - CNT_W'(1);
  end
endmodule

module regfile_wb_ctrl #(
  parameter int CNT_W      = 2,
  parameter int PRIO_FIXED = 0
) (
  input  logic               clk,
  input  logic               n_rst,
  regfile_wb_ctrl_if.slave   bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0][CNT_W-1:0] w_cnt;
  logic        r_pref1;     // 1: src1 wins the next tie (round-robin)
  logic        r_we;
  logic [4:0]  r_rd;
  logic [31:0] r_wd;
  logic        r_err;

  logic        w_g0, w_g1, w_acc, w_rd_nz, w_inc, w_dec, w_acc_zero;
  logic [4:0]  w_rd;
  logic [31:0] w_wd;

  // Arbitration: a lone valid always wins; ties go by priority mode
  assign w_g1 = bus.s1_valid & (~bus.s0_valid | (PRIO_FIXED != 0) | r_pref1);
  assign w_g0 = bus.s0_valid & ~w_g1;
  assign w_acc = w_g0 | w_g1;
  assign w_rd  = w_g1 ? bus.s1_rd : bus.s0_rd;
  assign w_wd  = w_g1 ? bus.s1_wd : bus.s0_wd;
  assign w_rd_nz    = |w_rd;
  assign w_acc_zero = (w_cnt[w_rd] == '0);

  assign bus.s0_ready = w_g0;
  assign bus.s1_ready = w_g1;

  // Scoreboard controls; x0 never counts
  assign bus.mark_ready = (w_cnt[bus.mark_rd] != CNT_MAX);
  assign w_inc = bus.mark_valid & bus.mark_ready & (|bus.mark_rd);
  assign w_dec = w_acc & w_rd_nz & ~w_acc_zero;

  assign w_cnt[0] = '0;
  for (genvar i = 1; i < 32; i++) begin : g_cnt
    regfile_wb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_inc   (w_inc & (bus.mark_rd == 5'(i))),
      .i_dec   (w_dec & (w_rd == 5'(i))),
      .i_flush (bus.flush),
      .o_cnt   (w_cnt[i])
    );
  end

  assign bus.rs1_busy = (|bus.rs1_q) & (w_cnt[bus.rs1_q] != '0);
  assign bus.rs2_busy = (|bus.rs2_q) & (w_cnt[bus.rs2_q] != '0);

  // Round-robin pointer moves only when something is granted
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)     r_pref1 <= 1'b0;
    else if (w_acc) r_pref1 <= w_g0;
  end

  // Registered write port; x0 writebacks are consumed without a write
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_we <= 1'b0;
      r_rd <= '0;
      r_wd <= '0;
    end else begin
      r_we <= w_acc & w_rd_nz;
      if (w_acc && w_rd_nz) begin
        r_rd <= w_rd;
        r_wd <= w_wd;
      end
    end
  end

  // Sticky underflow: retiring a register nobody marked (flush cycle excused)
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                                               r_err <= 1'b0;
    else if (w_acc && w_rd_nz && w_acc_zero && !bus.flush)    r_err <= 1'b1;
  end

  assign bus.rf_we         = r_we;
  assign bus.rf_rd         = r_rd;
  assign bus.rf_wd         = r_wd;
  assign bus.err_underflow = r_err;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios then random traffic, all
// checked against an array/integer reference model of the scoreboard.
module tb_regfile_wb_ctrl;
  localparam int CNT_W = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_ctrl_if bus();
  regfile_wb_ctrl #(.CNT_W(CNT_W), .PRIO_FIXED(0)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_cnt [32];
  int          m_last;      // source granted most recently (1 -> src0 preferred)
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_wd;
  bit          m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_last = 1; m_we = 0; m_rd = '0; m_wd = '0; m_err = 0;
  endtask

  // One clock: drive, check combinational outputs, advance model, check registered ones
  task automatic step(input bit s0v, input logic [4:0] s0rd, input logic [31:0] s0wd,
                      input bit s1v, input logic [4:0] s1rd, input logic [31:0] s1wd,
                      input bit mv, input logic [4:0] mrd, input bit fl,
                      input logic [4:0] q1, input logic [4:0] q2);
    int win;
    bit mready, inc, dec;
    logic [4:0] rd;
    logic [31:0] wd;
    bus.s0_valid = s0v; bus.s0_rd = s0rd; bus.s0_wd = s0wd;
    bus.s1_valid = s1v; bus.s1_rd = s1rd; bus.s1_wd = s1wd;
    bus.mark_valid = mv; bus.mark_rd = mrd; bus.flush = fl;
    bus.rs1_q = q1; bus.rs2_q = q2;
    #1;
    win = -1;
    if (s0v && s1v) win = 1 - m_last;
    else if (s0v)   win = 0;
    else if (s1v)   win = 1;
    mready = (m_cnt[mrd] < MAXC);
    chk("s0_ready",   bus.s0_ready,   32'(win == 0));
    chk("s1_ready",   bus.s1_ready,   32'(win == 1));
    chk("mark_ready", bus.mark_ready, 32'(mready));
    chk("rs1_busy",   bus.rs1_busy,   32'(q1 != 0 && m_cnt[q1] != 0));
    chk("rs2_busy",   bus.rs2_busy,   32'(q2 != 0 && m_cnt[q2] != 0));

    rd = (win == 1) ? s1rd : s0rd;
    wd = (win == 1) ? s1wd : s0wd;
    m_we = 0;
    dec = 0;
    if (win >= 0) begin
      m_last = win;
      if (rd != 0) begin
        m_we = 1; m_rd = rd; m_wd = wd;
        if (m_cnt[rd] == 0) begin
          if (!fl) m_err = 1;
        end else dec = 1;
      end
    end
    inc = mv && mready && (mrd != 0);
    if (fl) foreach (m_cnt[i]) m_cnt[i] = 0;
    else begin
      if (dec) m_cnt[rd]  = m_cnt[rd] - 1;
      if (inc) m_cnt[mrd] = m_cnt[mrd] + 1;
    end

    @(posedge clk); #1;
    chk("rf_we",  bus.rf_we, 32'(m_we));
    chk("rf_rd",  bus.rf_rd, 32'(m_rd));
    chk("rf_wd",  bus.rf_wd, m_wd);
    chk("err",    bus.err_underflow, 32'(m_err));
  endtask

  task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    bus.s0_valid = 0; bus.s0_rd = 0; bus.s0_wd = 0;
    bus.s1_valid = 0; bus.s1_rd = 0; bus.s1_wd = 0;
    bus.mark_valid = 0; bus.mark_rd = 0; bus.flush = 0;
    bus.rs1_q = 5; bus.rs2_q = 9;
    #12;
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_rf_rd", bus.rf_rd, 0);
    chk("rst_rf_wd", bus.rf_wd, 0);
    chk("rst_err",   bus.err_underflow, 0);
    chk("rst_busy",  bus.rs1_busy, 0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // single source: mark x5, ALU writes it back
    step(0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 0);
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);

    // round-robin contention on x1/x2
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 2);
    for (int i = 0; i < 4; i++)
      step(1, 1, 32'h100 + i, 1, 2, 32'h200 + i, 0, 0, 0, 1, 2);
    idle(1, 2);

    // saturation on x7
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0);
    step(0, 7, 0, 1, 7, 32'h77, 1, 7, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0);

    // same-cycle inc+dec on x9
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 9);
    step(1, 9, 32'h99, 0, 0, 0, 1, 9, 0, 0, 9);
    idle(0, 9);

    // x0 writeback, underflow on x3, flush with cnt[4]=2
    step(0, 0, 0, 1, 0, 32'h5A5A, 0, 0, 0, 3, 4);
    step(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 3, 4);
    step(0, 0, 0, 0, 0, 0, 1, 4, 0, 4, 3);
    step(0, 0, 0, 0, 0, 0, 1, 4, 0, 4, 3);
    step(0, 0, 0, 1, 6, 32'h66, 1, 4, 1, 4, 3);
    idle(4, 7);

    // random traffic over a narrow register range to create hazards
    for (int i = 0; i < 400; i++)
      step(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom), 5'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    // async reset mid-stream with a write pending and s0 still requesting
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 6, 0, 6, 0);
    step(0, 0, 0, 0, 0, 0, 1, 6, 0, 6, 0);
    step(1, 3, 32'hAB, 0, 0, 0, 0, 0, 0, 6, 0);
    step(1, 6, 32'hCAFE, 0, 0, 0, 0, 0, 0, 6, 0);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    chk("arst_rf_we", bus.rf_we, 32'(m_we));
    chk("arst_busy",  bus.rs1_busy, 0);
    chk("arst_err",   bus.err_underflow, 32'(m_err));
    @(posedge clk); #1;
    chk("arst_hold_we", bus.rf_we, 0);
    n_rst = 1'b1;
    step(1, 6, 32'h1234, 0, 0, 0, 0, 0, 0, 6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
